ex_issue_stage: RTL
===================

Name: ex_issue_stage

Overview:
- Registered decode/issue stage directly upstream of the 32-bit ALU.
- Accepts a decoded instruction bundle from ID and selects operands (register or immediate), with optional forwarding.
- Generates the 4-bit ALU control code and holds the result in a valid/ready pipeline register.
- Its outputs drive the ALU's operandA, operandB and ALU_control inputs directly.

Parameters:
- XLEN, 32, datapath width of operands and immediate.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard the held and incoming instruction.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept the bundle this cycle.
- opcode  in  7  RV32 opcode field.
- funct3  in  3  RV32 funct3.
- funct7_5  in  1  bit 30 of the instruction.
- rs1_addr, rs2_addr  in  5 each  source register indices.
- rs1_data, rs2_data  in  XLEN each  register file read data.
- imm  in  XLEN  sign-extended immediate.
- rd_in  in  5  destination register.
- fwd_valid  in  1  forwarding source valid (macro-gated).
- fwd_rd  in  5  forwarding destination index (macro-gated).
- fwd_data  in  XLEN  forwarding value (macro-gated).
- out_valid  out  1  output bundle valid.
- out_ready  in  1  ALU/EX consumer accepts the bundle.
- operandA  out  XLEN  ALU operand A.
- operandB  out  XLEN  ALU operand B.
- ALU_control  out  4  ALU operation code.
- rd_out  out  5  destination register; forced to 0 for branches.
- is_branch  out  1  BEQ/BNE; EX uses the ALU zero flag.
- branch_ne  out  1  1 = BNE.
- illegal  out  1  unsupported encoding.

Behaviour:
- Reset: on rst=1 at a clock edge, out_valid, operandA, operandB, ALU_control, rd_out, is_branch, branch_ne and illegal all go to 0. rst has priority over flush and all other inputs.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
  - On transfer in, all output registers load at the next edge and out_valid=1. Latency is 1 cycle.
  - On transfer out with no transfer in, out_valid goes to 0 and the data registers hold their last value.
  - While out_valid && !out_ready, every output is held stable.
  - Simultaneous in and out transfers give full throughput of one bundle per cycle.
- Flush: flush=1 sets out_valid=0 at the next edge and drops any bundle presented that cycle. in_ready is unaffected.
- Decode:
  - R-type (0110011): operandB = rs2 value.
  - I-ALU (0010011): operandB = imm.
  - BRANCH (1100011): operandB = rs2 value.
  - operandA = rs1 value in all cases.
- ALU_control mapping:
  - funct3 000: ADD (0000), or SUB (0001) if R-type && funct7_5.
  - funct3 111: AND (0010).
  - funct3 110: OR (0011).
  - funct3 100: XOR (0100).
  - funct3 001: SLL (0101).
  - funct3 101: SRL (0110); SRA (funct7_5=1) is illegal.
  - funct3 010: SLT (0111).
  - funct3 011: illegal.
  - I-type funct7_5 is ignored except for funct3 101.
- Branch decode:
  - funct3 000 → SUB, is_branch=1, branch_ne=0.
  - funct3 001 → SUB, is_branch=1, branch_ne=1.
  - Other funct3 → illegal.
- Any other opcode → illegal.
- Illegal bundles still transfer with out_valid=1, illegal=1, ALU_control=0000, operands 0, rd_out=0.
- Shift amounts pass through unmasked; the ALU owns shift semantics.

Optional Feature:
- Macro: EX_ISSUE_FWD_EN.
- Defined:
  - The rs1 value is fwd_data when fwd_valid && fwd_rd!=0 && fwd_rd==rs1_addr; same rule for rs2.
  - Selection is evaluated at the capture edge.
  - rs2 forwarding applies only where rs2 is used (R-type and branches).
- Undefined: fwd_* ports are absent and register data is used unchanged.

Test Plan:
- Reset mid-hold: out_valid=1, out_ready=0, assert rst for 1 cycle → all outputs 0 next cycle; in_ready=1.
- R-type SUB: opcode 0110011, funct3 000, funct7_5 1, rs1_data 10, rs2_data 3 → one cycle later out_valid=1, operandA=10, operandB=3, ALU_control=0001.
- I-type ADDI with back-pressure: imm 0xFFFFFFFF, rs1_data 5, out_ready=0 for 3 cycles → operandB=0xFFFFFFFF and ALU_control=0000 held for 3 cycles; in_ready=0 during the hold; accepted on the 4th cycle.
- Back-to-back stream of 8 bundles with out_ready=1 → 8 consecutive out_valid cycles, order preserved.
- BNE then illegal: BNE → is_branch=1, branch_ne=1, ALU_control=0001, rd_out=0; opcode 0110111 → illegal=1, ALU_control=0000.
- Flush and forwarding (EX_ISSUE_FWD_EN): flush with in_valid=1 → out_valid=0 next cycle. Then fwd_rd=5, fwd_data 0xABCD, rs1_addr=5 → operandA=0xABCD. With fwd_rd=0 → operandA=rs1_data.

Source files
------------

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: registered operand-select and ALU-control stage feeding the 32-bit ALU.
// Define EX_ISSUE_FWD_EN to add the fwd_* ports and rs1/rs2 forwarding; default build has none.
module ex_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd_in,
`ifdef EX_ISSUE_FWD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operandA,
  output logic [XLEN-1:0] operandB,
  output logic [3:0]      ALU_control,
  output logic [4:0]      rd_out,
  output logic            is_branch,
  output logic            branch_ne,
  output logic            illegal
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_e;

  logic            valid_q;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  alu_e            alu_q, alu_d;
  logic [4:0]      rd_q, rd_d;
  logic            br_q, br_d;
  logic            ne_q, ne_d;
  logic            ill_q, ill_d;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            take;

`ifdef EX_ISSUE_FWD_EN
  // x0 is never forwarded; rs2 forwarding only matters where rs2 is selected below
  assign rs1_val = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs1_addr)) ? fwd_data : rs1_data;
  assign rs2_val = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs2_addr)) ? fwd_data : rs2_data;
`else
  logic unused_addr;
  assign unused_addr = ^{rs1_addr, rs2_addr};
  assign rs1_val     = rs1_data;
  assign rs2_val     = rs2_data;
`endif

  assign in_ready = !valid_q || out_ready;
  assign take     = in_valid && in_ready && !flush;

  always_comb begin
    alu_d = ALU_ADD;
    opa_d = '0;
    opb_d = '0;
    rd_d  = '0;
    br_d  = 1'b0;
    ne_d  = 1'b0;
    ill_d = 1'b0;
    case (opcode)
      OP_R, OP_IMM: begin
        opa_d = rs1_val;
        opb_d = (opcode == OP_R) ? rs2_val : imm;
        rd_d  = rd_in;
        case (funct3)
          3'b000: alu_d = ((opcode == OP_R) && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111: alu_d = ALU_AND;
          3'b110: alu_d = ALU_OR;
          3'b100: alu_d = ALU_XOR;
          3'b001: alu_d = ALU_SLL;
          3'b101: begin
            if (funct7_5) ill_d = 1'b1;
            else          alu_d = ALU_SRL;
          end
          3'b010: alu_d = ALU_SLT;
          default: ill_d = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        opa_d = rs1_val;
        opb_d = rs2_val;
        alu_d = ALU_SUB;
        br_d  = 1'b1;
        ne_d  = funct3[0];
        if (funct3[2:1] != 2'b00) ill_d = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
    // illegal bundles carry nothing but the illegal flag
    if (ill_d) begin
      alu_d = ALU_ADD;
      opa_d = '0;
      opb_d = '0;
      rd_d  = '0;
      br_d  = 1'b0;
      ne_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      alu_q   <= ALU_ADD;
      rd_q    <= '0;
      br_q    <= 1'b0;
      ne_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (take) begin
      valid_q <= 1'b1;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      ne_q    <= ne_d;
      ill_q   <= ill_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign operandA    = opa_q;
  assign operandB    = opb_q;
  assign ALU_control = alu_q;
  assign rd_out      = rd_q;
  assign is_branch   = br_q;
  assign branch_ne   = ne_q;
  assign illegal     = ill_q;

endmodule
